// File: rtl/idu_is_cp0_queue.sv
// In-order CP0 issue queue: buffers dispatched CP0 ops in program order,
// tracks psrc1 readiness against the wakeup buses and issues only the head.
module idu_is_cp0_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2,
    parameter int unsigned WK_N  = 10
) (
    input  logic                 clk,
    input  logic                 rst_clk,
    input  logic                 rtu_global_flush,
    input  logic                 dis_cp0_vld,
    output logic                 dis_cp0_rdy,
    input  logic [4:0]           dis_cp0_iid,
    input  logic [6:0]           dis_cp0_opcode,
    input  logic                 dis_cp0_psrc1_vld,
    input  logic                 dis_cp0_psrc1_ready,
    input  logic [5:0]           dis_cp0_psrc1,
    input  logic                 dis_cp0_imm_vld,
    input  logic [63:0]          dis_cp0_imm,
    input  logic [WK_N-1:0]      wakeup_vld,
    input  logic [6*WK_N-1:0]    wakeup_preg,
    input  logic                 exu_cp0_rdy,
    output logic                 is_cp0_vld,
    output logic [4:0]           is_cp0_iid,
    output logic [6:0]           is_cp0_opcode,
    output logic                 is_cp0_psrc1_vld,
    output logic [5:0]           is_cp0_psrc1,
    output logic                 is_cp0_imm_vld,
    output logic [63:0]          is_cp0_imm,
    output logic [PTR_W:0]       cp0_q_cnt,
    output logic                 cp0_q_empty
);

    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic        vld;
        logic [4:0]  iid;
        logic [6:0]  opcode;
        logic        psrc1_vld;
        logic        psrc1_rdy;
        logic [5:0]  psrc1;
        logic        imm_vld;
        logic [63:0] imm;
    } entry_t;

    entry_t             q     [DEPTH];
    entry_t             q_nxt [DEPTH];
    entry_t             head_e;
    entry_t             new_e;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   cnt;
    logic [DEPTH-1:0]   ent_hit;
    logic               dis_hit;
    logic               enq;
    logic               deq;

    // Tag match of every wakeup source against each entry and the incoming op
    always_comb begin
        ent_hit = '0;
        dis_hit = 1'b0;
        for (int k = 0; k < int'(WK_N); k++) begin
            if (wakeup_vld[k] && (wakeup_preg[6*k +: 6] == dis_cp0_psrc1)) begin
                dis_hit = 1'b1;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (wakeup_vld[k] && (wakeup_preg[6*k +: 6] == q[i].psrc1)) begin
                    ent_hit[i] = 1'b1;
                end
            end
        end
    end

    assign head_e      = q[head];
    assign dis_cp0_rdy = (cnt < CNT_W'(DEPTH));
    assign is_cp0_vld  = head_e.vld & (head_e.psrc1_rdy | ~head_e.psrc1_vld)
                       & exu_cp0_rdy & ~rtu_global_flush;
    assign enq         = dis_cp0_vld & dis_cp0_rdy & ~rtu_global_flush;
    assign deq         = is_cp0_vld;

    // Released entries are zeroed, so an empty queue presents a zero payload
    assign is_cp0_iid       = head_e.iid;
    assign is_cp0_opcode    = head_e.opcode;
    assign is_cp0_psrc1_vld = head_e.psrc1_vld;
    assign is_cp0_psrc1     = head_e.psrc1;
    assign is_cp0_imm_vld   = head_e.imm_vld;
    assign is_cp0_imm       = head_e.imm;
    assign cp0_q_cnt        = cnt;
    assign cp0_q_empty      = (cnt == '0);

    always_comb begin
        new_e           = '0;
        new_e.vld       = 1'b1;
        new_e.iid       = dis_cp0_iid;
        new_e.opcode    = dis_cp0_opcode;
        new_e.psrc1_vld = dis_cp0_psrc1_vld;
        new_e.psrc1_rdy = dis_cp0_psrc1_ready | dis_hit;
        new_e.psrc1     = dis_cp0_psrc1;
        new_e.imm_vld   = dis_cp0_imm_vld;
        new_e.imm       = dis_cp0_imm;
    end

    // Entry next-state: wakeup, then release at head, then write at tail
    always_comb begin
        q_nxt = q;
        if (rst_clk || rtu_global_flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_nxt[i] = '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (q[i].vld && ent_hit[i]) begin
                    q_nxt[i].psrc1_rdy = 1'b1;
                end
            end
            if (deq) begin
                q_nxt[head] = '0;
            end
            if (enq) begin
                q_nxt[tail] = new_e;
            end
        end
    end

    always_ff @(posedge clk) begin
        q <= q_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst_clk || rtu_global_flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + PTR_W'(deq);
            tail <= tail + PTR_W'(enq);
            cnt  <= cnt + CNT_W'(enq) - CNT_W'(deq);
        end
    end

endmodule

// File: tb/tb_idu_is_cp0_queue.sv
// Bench for idu_is_cp0_queue: directed scenarios plus a randomized run
// compared each cycle against a queue-level model of the issue rules.
module tb_idu_is_cp0_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned WK_N  = 10;

    logic               clk = 1'b0;
    logic               rst_clk;
    logic               rtu_global_flush;
    logic               dis_cp0_vld;
    logic               dis_cp0_rdy;
    logic [4:0]         dis_cp0_iid;
    logic [6:0]         dis_cp0_opcode;
    logic               dis_cp0_psrc1_vld;
    logic               dis_cp0_psrc1_ready;
    logic [5:0]         dis_cp0_psrc1;
    logic               dis_cp0_imm_vld;
    logic [63:0]        dis_cp0_imm;
    logic [WK_N-1:0]    wakeup_vld;
    logic [6*WK_N-1:0]  wakeup_preg;
    logic               exu_cp0_rdy;
    logic               is_cp0_vld;
    logic [4:0]         is_cp0_iid;
    logic [6:0]         is_cp0_opcode;
    logic               is_cp0_psrc1_vld;
    logic [5:0]         is_cp0_psrc1;
    logic               is_cp0_imm_vld;
    logic [63:0]        is_cp0_imm;
    logic [PTR_W:0]     cp0_q_cnt;
    logic               cp0_q_empty;

    int checks   = 0;
    int failures = 0;

    idu_is_cp0_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .WK_N(WK_N)) dut (
        .clk(clk), .rst_clk(rst_clk), .rtu_global_flush(rtu_global_flush),
        .dis_cp0_vld(dis_cp0_vld), .dis_cp0_rdy(dis_cp0_rdy),
        .dis_cp0_iid(dis_cp0_iid), .dis_cp0_opcode(dis_cp0_opcode),
        .dis_cp0_psrc1_vld(dis_cp0_psrc1_vld), .dis_cp0_psrc1_ready(dis_cp0_psrc1_ready),
        .dis_cp0_psrc1(dis_cp0_psrc1), .dis_cp0_imm_vld(dis_cp0_imm_vld),
        .dis_cp0_imm(dis_cp0_imm), .wakeup_vld(wakeup_vld), .wakeup_preg(wakeup_preg),
        .exu_cp0_rdy(exu_cp0_rdy), .is_cp0_vld(is_cp0_vld), .is_cp0_iid(is_cp0_iid),
        .is_cp0_opcode(is_cp0_opcode), .is_cp0_psrc1_vld(is_cp0_psrc1_vld),
        .is_cp0_psrc1(is_cp0_psrc1), .is_cp0_imm_vld(is_cp0_imm_vld),
        .is_cp0_imm(is_cp0_imm), .cp0_q_cnt(cp0_q_cnt), .cp0_q_empty(cp0_q_empty)
    );

    always #5 clk = ~clk;

    // Reference model: program-ordered list of pending instructions
    typedef struct {
        logic [4:0]  iid;
        logic [6:0]  opcode;
        logic        psrc1_vld;
        logic        rdy;
        logic [5:0]  psrc1;
        logic        imm_vld;
        logic [63:0] imm;
    } m_ent_t;

    m_ent_t mq[$];

    function automatic bit m_hit(input logic [5:0] p);
        for (int k = 0; k < int'(WK_N); k++) begin
            if (wakeup_vld[k] && wakeup_preg[6*k +: 6] == p) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_issue();
        if (mq.size() == 0 || !exu_cp0_rdy || rtu_global_flush) return 1'b0;
        return mq[0].rdy || !mq[0].psrc1_vld;
    endfunction

    task automatic model_step();
        bit acc;
        bit iss;
        m_ent_t e;
        acc = (mq.size() < DEPTH);
        iss = m_issue();
        if (rst_clk || rtu_global_flush) begin
            mq.delete();
        end else begin
            foreach (mq[i]) if (m_hit(mq[i].psrc1)) mq[i].rdy = 1'b1;
            if (iss) void'(mq.pop_front());
            if (dis_cp0_vld && acc) begin
                e.iid = dis_cp0_iid;         e.opcode  = dis_cp0_opcode;
                e.psrc1_vld = dis_cp0_psrc1_vld;
                e.rdy = dis_cp0_psrc1_ready || m_hit(dis_cp0_psrc1);
                e.psrc1 = dis_cp0_psrc1;     e.imm_vld = dis_cp0_imm_vld;
                e.imm = dis_cp0_imm;
                mq.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        rtu_global_flush = 1'b0;  dis_cp0_vld = 1'b0;   dis_cp0_iid = '0;
        dis_cp0_opcode = '0;      dis_cp0_psrc1_vld = 1'b0;
        dis_cp0_psrc1_ready = 1'b0; dis_cp0_psrc1 = '0;
        dis_cp0_imm_vld = 1'b0;   dis_cp0_imm = '0;
        wakeup_vld = '0;          wakeup_preg = '0;
    endtask

    task automatic set_dis(input logic [4:0] iid, input logic [6:0] op,
                           input logic pv, input logic prdy, input logic [5:0] p);
        dis_cp0_vld = 1'b1;     dis_cp0_iid = iid;   dis_cp0_opcode = op;
        dis_cp0_psrc1_vld = pv; dis_cp0_psrc1_ready = prdy; dis_cp0_psrc1 = p;
        dis_cp0_imm_vld = 1'b1; dis_cp0_imm = {59'h0, iid};
    endtask

    task automatic test_reset();
        idle_inputs();
        exu_cp0_rdy = 1'b0;
        rst_clk = 1'b1;
        tick();
        tick();
        rst_clk = 1'b0;
        #1;
        checks++;
        if (dis_cp0_rdy !== 1'b1 || is_cp0_vld !== 1'b0 || cp0_q_cnt !== 3'd0 || cp0_q_empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl got rdy=%b vld=%b cnt=%0d empty=%b exp 1 0 0 1",
                     dis_cp0_rdy, is_cp0_vld, cp0_q_cnt, cp0_q_empty);
        end
        checks++;
        if ({is_cp0_iid, is_cp0_opcode, is_cp0_psrc1_vld, is_cp0_psrc1, is_cp0_imm_vld, is_cp0_imm} !== '0) begin
            failures++;
            $display("FAIL reset_payload got iid=%0d op=%0h imm=%0h exp all 0", is_cp0_iid, is_cp0_opcode, is_cp0_imm);
        end
    endtask

    task automatic test_no_src();
        exu_cp0_rdy = 1'b1;
        set_dis(5'd3, 7'h12, 1'b0, 1'b0, 6'd0);
        #1;
        checks++;
        if (is_cp0_vld !== 1'b0) begin
            failures++; $display("FAIL nosrc_same_cycle got vld=%b exp 0", is_cp0_vld);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (is_cp0_vld !== 1'b1 || is_cp0_iid !== 5'd3 || is_cp0_opcode !== 7'h12) begin
            failures++;
            $display("FAIL nosrc_issue got vld=%b iid=%0d op=%0h exp 1 3 12", is_cp0_vld, is_cp0_iid, is_cp0_opcode);
        end
        tick();
        #1;
        checks++;
        if (cp0_q_empty !== 1'b1 || cp0_q_cnt !== 3'd0) begin
            failures++; $display("FAIL nosrc_empty got empty=%b cnt=%0d exp 1 0", cp0_q_empty, cp0_q_cnt);
        end
    endtask

    task automatic test_wakeup();
        set_dis(5'd5, 7'h01, 1'b1, 1'b0, 6'd20);
        tick();
        idle_inputs();
        tick();
        #1;
        checks++;
        if (is_cp0_vld !== 1'b0 || cp0_q_cnt !== 3'd1) begin
            failures++; $display("FAIL wake_wait got vld=%b cnt=%0d exp 0 1", is_cp0_vld, cp0_q_cnt);
        end
        wakeup_vld[3] = 1'b1;
        wakeup_preg[23:18] = 6'd20;
        #1;
        checks++;
        if (is_cp0_vld !== 1'b0) begin
            failures++; $display("FAIL wake_same_cycle got vld=%b exp 0", is_cp0_vld);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (is_cp0_vld !== 1'b1 || is_cp0_iid !== 5'd5 || is_cp0_psrc1 !== 6'd20) begin
            failures++;
            $display("FAIL wake_issue got vld=%b iid=%0d psrc1=%0d exp 1 5 20", is_cp0_vld, is_cp0_iid, is_cp0_psrc1);
        end
        tick();
    endtask

    task automatic test_create_wakeup();
        set_dis(5'd7, 7'h02, 1'b1, 1'b0, 6'd9);
        wakeup_vld[9] = 1'b1;
        wakeup_preg[59:54] = 6'd9;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (is_cp0_vld !== 1'b1 || is_cp0_iid !== 5'd7) begin
            failures++; $display("FAIL create_wake got vld=%b iid=%0d exp 1 7", is_cp0_vld, is_cp0_iid);
        end
        tick();
    endtask

    task automatic test_full();
        exu_cp0_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_dis(5'(i), 7'h10, 1'b0, 1'b0, 6'd0);
            tick();
        end
        set_dis(5'd9, 7'h10, 1'b0, 1'b0, 6'd0);
        #1;
        checks++;
        if (cp0_q_cnt !== 3'd4 || dis_cp0_rdy !== 1'b0) begin
            failures++; $display("FAIL full_state got cnt=%0d rdy=%b exp 4 0", cp0_q_cnt, dis_cp0_rdy);
        end
        tick();
        idle_inputs();
        exu_cp0_rdy = 1'b1;
        #1;
        checks++;
        if (cp0_q_cnt !== 3'd4 || dis_cp0_rdy !== 1'b0 || is_cp0_vld !== 1'b1) begin
            failures++;
            $display("FAIL full_drop got cnt=%0d rdy=%b vld=%b exp 4 0 1", cp0_q_cnt, dis_cp0_rdy, is_cp0_vld);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (is_cp0_vld !== 1'b1 || is_cp0_iid !== 5'(i)) begin
                failures++; $display("FAIL full_order got vld=%b iid=%0d exp 1 %0d", is_cp0_vld, is_cp0_iid, i);
            end
            tick();
            #1;
            checks++;
            if (dis_cp0_rdy !== 1'b1 || cp0_q_cnt !== 3'(4 - i)) begin
                failures++;
                $display("FAIL full_drain got rdy=%b cnt=%0d exp 1 %0d", dis_cp0_rdy, cp0_q_cnt, 4 - i);
            end
        end
    endtask

    task automatic test_no_bypass();
        exu_cp0_rdy = 1'b1;
        set_dis(5'd1, 7'h20, 1'b1, 1'b0, 6'd30);
        tick();
        set_dis(5'd2, 7'h21, 1'b0, 1'b0, 6'd0);
        tick();
        idle_inputs();
        #1;
        checks++;
        if (is_cp0_vld !== 1'b0 || cp0_q_cnt !== 3'd2 || is_cp0_iid !== 5'd1) begin
            failures++;
            $display("FAIL nobypass_hold got vld=%b cnt=%0d iid=%0d exp 0 2 1", is_cp0_vld, cp0_q_cnt, is_cp0_iid);
        end
        wakeup_vld[0] = 1'b1;
        wakeup_preg[5:0] = 6'd30;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (is_cp0_vld !== 1'b1 || is_cp0_iid !== 5'd1) begin
            failures++; $display("FAIL nobypass_first got vld=%b iid=%0d exp 1 1", is_cp0_vld, is_cp0_iid);
        end
        tick();
        #1;
        checks++;
        if (is_cp0_vld !== 1'b1 || is_cp0_iid !== 5'd2) begin
            failures++; $display("FAIL nobypass_second got vld=%b iid=%0d exp 1 2", is_cp0_vld, is_cp0_iid);
        end
        tick();
    endtask

    task automatic test_flush_wrap();
        exu_cp0_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_dis(5'(20 + i), 7'h30, 1'b0, 1'b0, 6'd0);
            tick();
        end
        set_dis(5'd31, 7'h31, 1'b0, 1'b0, 6'd0);
        rtu_global_flush = 1'b1;
        exu_cp0_rdy = 1'b1;
        #1;
        checks++;
        if (is_cp0_vld !== 1'b0 || dis_cp0_rdy !== 1'b1) begin
            failures++; $display("FAIL flush_cycle got vld=%b rdy=%b exp 0 1", is_cp0_vld, dis_cp0_rdy);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (cp0_q_cnt !== 3'd0 || cp0_q_empty !== 1'b1 || is_cp0_vld !== 1'b0) begin
            failures++;
            $display("FAIL flush_after got cnt=%0d empty=%b vld=%b exp 0 1 0", cp0_q_cnt, cp0_q_empty, is_cp0_vld);
        end
        for (int i = 0; i < 6; i++) begin
            set_dis(5'(10 + i), 7'(i), 1'b0, 1'b0, 6'd0);
            tick();
            idle_inputs();
            #1;
            checks++;
            if (is_cp0_vld !== 1'b1 || is_cp0_iid !== 5'(10 + i) || is_cp0_opcode !== 7'(i)) begin
                failures++;
                $display("FAIL wrap_pair got vld=%b iid=%0d exp 1 %0d", is_cp0_vld, is_cp0_iid, 10 + i);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [PTR_W:0] e_cnt;
        bit e_vld;
        for (int c = 0; c < 400; c++) begin
            idle_inputs();
            if ($urandom_range(3) != 0) begin
                set_dis(5'($urandom), 7'($urandom), 1'($urandom), 1'($urandom_range(5) == 0),
                        6'($urandom_range(7)));
                dis_cp0_imm_vld = 1'($urandom);
                dis_cp0_imm = {$urandom, $urandom};
            end
            for (int k = 0; k < int'(WK_N); k++) begin
                wakeup_vld[k] = ($urandom_range(9) == 0);
                wakeup_preg[6*k +: 6] = 6'($urandom_range(7));
            end
            exu_cp0_rdy = ($urandom_range(3) != 0);
            rtu_global_flush = ($urandom_range(39) == 0);
            #1;
            e_cnt = (PTR_W + 1)'(mq.size());
            e_vld = m_issue();
            checks++;
            if (is_cp0_vld !== e_vld || cp0_q_cnt !== e_cnt || dis_cp0_rdy !== (mq.size() < DEPTH)
                || cp0_q_empty !== (mq.size() == 0)) begin
                failures++;
                $display("FAIL rand_ctrl cyc=%0d got vld=%b cnt=%0d rdy=%b empty=%b exp vld=%b cnt=%0d",
                         c, is_cp0_vld, cp0_q_cnt, dis_cp0_rdy, cp0_q_empty, e_vld, e_cnt);
            end
            if (mq.size() != 0) begin
                checks++;
                if (is_cp0_iid !== mq[0].iid || is_cp0_opcode !== mq[0].opcode
                    || is_cp0_psrc1_vld !== mq[0].psrc1_vld || is_cp0_psrc1 !== mq[0].psrc1
                    || is_cp0_imm_vld !== mq[0].imm_vld || is_cp0_imm !== mq[0].imm) begin
                    failures++;
                    $display("FAIL rand_payload cyc=%0d got iid=%0d op=%0h imm=%0h exp iid=%0d op=%0h imm=%0h",
                             c, is_cp0_iid, is_cp0_opcode, is_cp0_imm, mq[0].iid, mq[0].opcode, mq[0].imm);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_no_src();
        test_wakeup();
        test_create_wakeup();
        test_full();
        test_no_bypass();
        test_flush_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
